// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - Iterative MIPS multiply/divide unit with HI/LO registers.
// Optional signed MULT/DIV support is enabled by defining MDU_SIGNED_EN.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [1:0]            mdu_operation_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  mthi_i,
    input  logic                  mtlo_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            is_div_q, is_div_d;
    logic            b_zero_q, b_zero_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    a_raw_q, a_raw_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            done_q, done_d;

    logic [W-1:0]    mag_a, mag_b;

`ifdef MDU_SIGNED_EN
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic            signed_op;

    assign signed_op = ~mdu_operation_i[0];
    assign mag_a     = (signed_op && a_i[W-1]) ? (~a_i + 1'b1) : a_i;
    assign mag_b     = (signed_op && b_i[W-1]) ? (~b_i + 1'b1) : b_i;
    assign sign_a_d  = (state_q == S_IDLE && start_i) ? (signed_op & a_i[W-1]) : sign_a_q;
    assign sign_b_d  = (state_q == S_IDLE && start_i) ? (signed_op & b_i[W-1]) : sign_b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
        end
    end
`else
    logic            unused_op_sign;

    assign unused_op_sign = mdu_operation_i[0];
    assign mag_a          = a_i;
    assign mag_b          = b_i;
`endif

    // Multiply step: conditional add into the upper half, then shift right.
    logic [W:0]      mul_sum;
    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});

    // Divide step: shift the next dividend bit into the remainder and try to subtract.
    logic [W:0]      div_shift;
    logic [W:0]      div_diff;
    logic            div_ge;
    assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});

    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;

    always_comb begin
        prod_fix = acc_q;
        quo_fix  = acc_q[W-1:0];
        rem_fix  = acc_q[2*W-1:W];
`ifdef MDU_SIGNED_EN
        if (sign_a_q ^ sign_b_q) begin
            prod_fix = ~acc_q + 1'b1;
            quo_fix  = ~acc_q[W-1:0] + 1'b1;
        end
        if (sign_a_q) begin
            rem_fix = ~acc_q[2*W-1:W] + 1'b1;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        b_zero_d = b_zero_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    count_d  = '0;
                    is_div_d = mdu_operation_i[1];
                    b_zero_d = (b_i == '0);
                    a_raw_d  = a_i;
                    // Divide keeps the divisor as the step operand; multiply keeps the multiplicand.
                    if (mdu_operation_i[1]) begin
                        opnd_d = mag_b;
                        acc_d  = {{W{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{W{1'b0}}, mag_b};
                    end
                end else begin
                    if (mthi_i) hi_d = a_i;
                    if (mtlo_i) lo_d = a_i;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_d = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]),
                             acc_q[W-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(W-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (b_zero_q) begin
                        hi_d = a_raw_q;
                        lo_d = {W{1'b1}};
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            b_zero_q <= b_zero_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - Self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi_i;
    logic        mtlo_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .mdu_operation_i (op),
        .a_i             (a),
        .b_i             (b),
        .mthi_i          (mthi_i),
        .mtlo_i          (mtlo_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .hi_o            (hi_o),
        .lo_o            (lo_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic   signed_op;
        longint sx, sy, q, r, p;
`ifdef MDU_SIGNED_EN
        signed_op = ~o[0];
`else
        signed_op = 1'b0;
`endif
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o[1]) begin
            if (signed_op) begin
                p = sx * sy;
                return p;
            end
            return {32'd0, x} * {32'd0, y};
        end
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (signed_op) begin
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
        end
        return {x % y, x / y};
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int cycles, output logic done_seen,
                         output logic [31:0] h, output logic [31:0] l);
        op = o; a = x; b = y; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        cycles = 0;
        while (busy_o && cycles < 100) begin
            cycles++;
            @(posedge clk); #1;
        end
        done_seen = done_o;
        h = hi_o;
        l = lo_o;
    endtask

    task automatic test_reset();
        reset = 1'b0; start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
        op = 2'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done_o); end
        n_checks++; if (hi_o !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi_o); end
        n_checks++; if (lo_o !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo_o); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [7];
        logic [31:0] t_a  [7];
        logic [31:0] t_b  [7];
        logic [31:0] t_hi [7];
        logic [31:0] t_lo [7];
        int          cyc;
        logic        dn;
        logic [31:0] h, l;
        t_op[0] = 2'b01; t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'hFFFF_FFFF; t_hi[0] = 32'hFFFF_FFFE; t_lo[0] = 32'h0000_0001;
        t_op[1] = 2'b00; t_a[1] = 32'hFFFF_FFFD; t_b[1] = 32'd5;
        t_op[2] = 2'b10; t_a[2] = 32'hFFFF_FFF9; t_b[2] = 32'd2;
        t_op[3] = 2'b11; t_a[3] = 32'd100;       t_b[3] = 32'd7;       t_hi[3] = 32'd2;         t_lo[3] = 32'd14;
        t_op[4] = 2'b11; t_a[4] = 32'h64;        t_b[4] = 32'd0;       t_hi[4] = 32'h64;        t_lo[4] = 32'hFFFF_FFFF;
        t_op[5] = 2'b10; t_a[5] = 32'h8000_0000; t_b[5] = 32'hFFFF_FFFF;
        t_op[6] = 2'b10; t_a[6] = 32'hFFFF_FFF9; t_b[6] = 32'd0;       t_hi[6] = 32'hFFFF_FFF9; t_lo[6] = 32'hFFFF_FFFF;
`ifdef MDU_SIGNED_EN
        t_hi[1] = 32'hFFFF_FFFF; t_lo[1] = 32'hFFFF_FFF1;
        t_hi[2] = 32'hFFFF_FFFF; t_lo[2] = 32'hFFFF_FFFD;
        t_hi[5] = 32'h0000_0000; t_lo[5] = 32'h8000_0000;
`else
        t_hi[1] = 32'h0000_0004; t_lo[1] = 32'hFFFF_FFF1;
        t_hi[2] = 32'h0000_0001; t_lo[2] = 32'h7FFF_FFFC;
        t_hi[5] = 32'h8000_0000; t_lo[5] = 32'h0000_0000;
`endif
        for (int i = 0; i < 7; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], cyc, dn, h, l);
            n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want 33", i, cyc); end
            n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL dir%0d_done got %0b want 1", i, dn); end
            n_checks++; if (h !== t_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi got %h want %h", i, h, t_hi[i]); end
            n_checks++; if (l !== t_lo[i]) begin n_fail++; $display("FAIL dir%0d_lo got %h want %h", i, l, t_lo[i]); end
            @(posedge clk); #1;
            n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width got %0b want 0", i, done_o); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] exp;
        int          cyc;
        logic        dn;
        logic [31:0] h, l;
        for (int i = 0; i < 25; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 20);
                2:       y = -$urandom_range(1, 20);
                default: y = $urandom;
            endcase
            exp = model(o, x, y);
            do_op(o, x, y, cyc, dn, h, l);
            n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL rnd%0d_busy_cycles got %0d want 33", i, cyc); end
            n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_done got %0b want 1", i, dn); end
            n_checks++; if (h !== exp[63:32]) begin n_fail++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, o, x, y, h, exp[63:32]); end
            n_checks++; if (l !== exp[31:0]) begin n_fail++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, o, x, y, l, exp[31:0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2;
        logic [63:0] e1, e2;
        int          cyc1, cyc2;
        logic        dn1, dn2;
        logic [31:0] h1, l1, h2, l2;
        x1 = $urandom; y1 = $urandom;
        x2 = $urandom; y2 = $urandom_range(1, 1000);
        e1 = model(2'b01, x1, y1);
        e2 = model(2'b11, x2, y2);
        do_op(2'b01, x1, y1, cyc1, dn1, h1, l1);
        do_op(2'b11, x2, y2, cyc2, dn2, h2, l2);
        n_checks++; if (dn1 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got %0b want 1", dn1); end
        n_checks++; if ({h1, l1} !== e1) begin n_fail++; $display("FAIL b2b_first_result got %h want %h", {h1, l1}, e1); end
        n_checks++; if (cyc2 != 33) begin n_fail++; $display("FAIL b2b_second_cycles got %0d want 33", cyc2); end
        n_checks++; if ({h2, l2} !== e2) begin n_fail++; $display("FAIL b2b_second_result got %h want %h", {h2, l2}, e2); end
    endtask

    task automatic test_ignore_busy();
        int cyc;
        op = 2'b01; a = 32'd6; b = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
        while (busy_o && cyc < 100) begin
            cyc++;
            if (cyc == 5) begin
                start_i = 1'b1; mthi_i = 1'b1; mtlo_i = 1'b1;
                op = 2'b10; a = 32'hDEAD_BEEF; b = 32'd3;
            end else begin
                start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
        n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL ignore_busy_cycles got %0d want 33", cyc); end
        n_checks++; if (hi_o !== 32'd0) begin n_fail++; $display("FAIL ignore_busy_hi got %h want 0", hi_o); end
        n_checks++; if (lo_o !== 32'd42) begin n_fail++; $display("FAIL ignore_busy_lo got %h want 2a", lo_o); end
        @(posedge clk); #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_no_restart got %0b want 0", busy_o); end
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        a = 32'hAAAA_5555; mthi_i = 1'b1; mtlo_i = 1'b1;
        @(posedge clk); #1;
        mthi_i = 1'b0; mtlo_i = 1'b0;
        n_checks++; if (hi_o !== 32'hAAAA_5555) begin n_fail++; $display("FAIL move_both_hi got %h want aaaa5555", hi_o); end
        n_checks++; if (lo_o !== 32'hAAAA_5555) begin n_fail++; $display("FAIL move_both_lo got %h want aaaa5555", lo_o); end
        op = 2'b01; a = 32'd6; b = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %0b want 0", busy_o); end
        n_checks++; if (hi_o !== 32'd0) begin n_fail++; $display("FAIL abort_hi got %h want 0", hi_o); end
        n_checks++; if (lo_o !== 32'd0) begin n_fail++; $display("FAIL abort_lo got %h want 0", lo_o); end
        @(posedge clk); #1;
        reset = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %0b want 0", saw_done); end
    endtask

    task automatic test_move();
        logic [31:0] h0;
        logic [63:0] exp;
        int          cyc;
        h0 = hi_o;
        a = 32'h1234; mtlo_i = 1'b1;
        @(posedge clk); #1;
        mtlo_i = 1'b0;
        n_checks++; if (lo_o !== 32'h1234) begin n_fail++; $display("FAIL mtlo_lo got %h want 1234", lo_o); end
        n_checks++; if (hi_o !== h0) begin n_fail++; $display("FAIL mtlo_hi_hold got %h want %h", hi_o, h0); end
        a = 32'h0BAD_F00D; mthi_i = 1'b1;
        @(posedge clk); #1;
        mthi_i = 1'b0;
        n_checks++; if (hi_o !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mthi_hi got %h want 0badf00d", hi_o); end
        n_checks++; if (lo_o !== 32'h1234) begin n_fail++; $display("FAIL mthi_lo_hold got %h want 1234", lo_o); end
        exp = model(2'b01, 32'h55, 32'd3);
        op = 2'b01; a = 32'h55; b = 32'd3; start_i = 1'b1; mthi_i = 1'b1; mtlo_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL start_wins_busy got %0b want 1", busy_o); end
        n_checks++; if ({hi_o, lo_o} !== {32'h0BAD_F00D, 32'h1234}) begin n_fail++; $display("FAIL start_wins_move_dropped got %h %h want 0badf00d 00001234", hi_o, lo_o); end
        cyc = 0;
        while (busy_o && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        n_checks++; if ({hi_o, lo_o} !== exp) begin n_fail++; $display("FAIL start_wins_result got %h want %h", {hi_o, lo_o}, exp); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
